// File: rtl/debounce_scheduler_if.sv
// Button/debounce signal bundle for debounce_scheduler.
// master drives raw buttons and enable; slave returns clean levels and strobes.
interface debounce_scheduler_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] btn_in;
    logic            enable;
    logic            tick;
    logic [N_CH-1:0] btn_level;
    logic [N_CH-1:0] btn_press;
    logic [N_CH-1:0] btn_release;
    logic [N_CH-1:0] btn_long;

    modport master (
        output btn_in,
        output enable,
        input  tick,
        input  btn_level,
        input  btn_press,
        input  btn_release,
        input  btn_long
    );

    modport slave (
        input  btn_in,
        input  enable,
        output tick,
        output btn_level,
        output btn_press,
        output btn_release,
        output btn_long
    );
endinterface

// File: rtl/debounce_scheduler.sv
// Multi-channel debouncer driven by one shared sample-tick prescaler.
// Define DEBOUNCE_SCHED_LONG_PRESS_EN to build the per-channel long-press detector.
module debounce_scheduler #(
    parameter int N_CH         = 4,
    parameter int TICK_MAX     = 500000,
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 64
) (
    input  logic                 clk,
    input  logic                 rst_a,
    debounce_scheduler_if.slave  bus
);
    localparam int PW = (TICK_MAX > 0) ? $clog2(TICK_MAX + 1) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);

    localparam logic [PW-1:0] PRE_TOP  = PW'(TICK_MAX);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        S_REL,
        S_PPEND,
        S_PRESS,
        S_RPEND
    } state_t;

    logic [PW-1:0]   r_pre;
    logic            r_tick;
    logic [N_CH-1:0] r_sync1;
    logic [N_CH-1:0] r_sync2;
    state_t          r_state [N_CH];
    logic [CW-1:0]   r_cnt   [N_CH];
    logic [N_CH-1:0] r_level;
    logic [N_CH-1:0] r_press;
    logic [N_CH-1:0] r_release;

    state_t          w_state_nx [N_CH];
    logic [CW-1:0]   w_cnt_nx   [N_CH];
    logic [N_CH-1:0] w_level_nx;

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (!bus.enable) begin
            r_pre  <= '0;
            r_tick <= 1'b0;
        end else if (r_pre == PRE_TOP) begin
            r_pre  <= '0;
            r_tick <= 1'b1;
        end else begin
            r_pre  <= r_pre + 1'b1;
            r_tick <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= bus.btn_in;
            r_sync2 <= r_sync1;
        end
    end

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            w_state_nx[i] = r_state[i];
            w_cnt_nx[i]   = r_cnt[i];
            if (!bus.enable) begin
                // Abandon any pending change; the accepted level stays put.
                if (r_state[i] == S_PPEND) w_state_nx[i] = S_REL;
                if (r_state[i] == S_RPEND) w_state_nx[i] = S_PRESS;
                w_cnt_nx[i] = '0;
            end else if (r_tick) begin
                case (r_state[i])
                    S_REL: begin
                        if (r_sync2[i]) begin
                            if (STABLE_TICKS == 1) begin
                                w_state_nx[i] = S_PRESS;
                                w_cnt_nx[i]   = '0;
                            end else begin
                                w_state_nx[i] = S_PPEND;
                                w_cnt_nx[i]   = CNT_ONE;
                            end
                        end
                    end
                    S_PPEND: begin
                        if (!r_sync2[i]) begin
                            w_state_nx[i] = S_REL;
                            w_cnt_nx[i]   = '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            w_state_nx[i] = S_PRESS;
                            w_cnt_nx[i]   = '0;
                        end else begin
                            w_cnt_nx[i] = r_cnt[i] + 1'b1;
                        end
                    end
                    S_PRESS: begin
                        if (!r_sync2[i]) begin
                            if (STABLE_TICKS == 1) begin
                                w_state_nx[i] = S_REL;
                                w_cnt_nx[i]   = '0;
                            end else begin
                                w_state_nx[i] = S_RPEND;
                                w_cnt_nx[i]   = CNT_ONE;
                            end
                        end
                    end
                    S_RPEND: begin
                        if (r_sync2[i]) begin
                            w_state_nx[i] = S_PRESS;
                            w_cnt_nx[i]   = '0;
                        end else if (r_cnt[i] == CNT_LAST) begin
                            w_state_nx[i] = S_REL;
                            w_cnt_nx[i]   = '0;
                        end else begin
                            w_cnt_nx[i] = r_cnt[i] + 1'b1;
                        end
                    end
                    default: begin
                        w_state_nx[i] = S_REL;
                        w_cnt_nx[i]   = '0;
                    end
                endcase
            end
            w_level_nx[i] = (w_state_nx[i] == S_PRESS) ||
                            (w_state_nx[i] == S_RPEND);
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= S_REL;
                r_cnt[i]   <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                r_state[i] <= w_state_nx[i];
                r_cnt[i]   <= w_cnt_nx[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_level   <= '0;
            r_press   <= '0;
            r_release <= '0;
        end else begin
            r_level   <= w_level_nx;
            r_press   <= w_level_nx & ~r_level;
            r_release <= ~w_level_nx & r_level;
        end
    end

    assign bus.tick        = r_tick;
    assign bus.btn_level   = r_level;
    assign bus.btn_press   = r_press;
    assign bus.btn_release = r_release;

`ifdef DEBOUNCE_SCHED_LONG_PRESS_EN
    localparam int HW = (LONG_TICKS > 0) ? $clog2(LONG_TICKS + 1) : 1;
    localparam logic [HW-1:0] HOLD_TOP  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_TICKS - 1);

    logic [HW-1:0]   r_hold [N_CH];
    logic [N_CH-1:0] r_long;

    // Hold time restarts only on a new press, so a release bounce cannot re-fire.
    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            r_long <= '0;
            for (int i = 0; i < N_CH; i++) r_hold[i] <= '0;
        end else begin
            r_long <= '0;
            for (int i = 0; i < N_CH; i++) begin
                if (w_level_nx[i] && !r_level[i]) begin
                    r_hold[i] <= '0;
                end else if (r_tick && bus.enable && r_level[i] &&
                             r_hold[i] != HOLD_TOP) begin
                    r_hold[i] <= r_hold[i] + 1'b1;
                    if (r_hold[i] == HOLD_LAST) r_long[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.btn_long = r_long;
`else
    assign bus.btn_long = '0;
`endif
endmodule

// File: tb/tb_debounce_scheduler.sv
// Directed bench for debounce_scheduler (TICK_MAX=9, STABLE_TICKS=3, LONG_TICKS=5).
// Long-press expectations follow DEBOUNCE_SCHED_LONG_PRESS_EN.
module tb_debounce_scheduler;
    logic clk;
    logic rst_a;
    int   checks = 0;
    int   errors = 0;
    int   n_press [4];
    int   n_rel   [4];
    int   n_long  [4];

    debounce_scheduler_if #(.N_CH(4)) bus ();

    debounce_scheduler #(
        .N_CH(4),
        .TICK_MAX(9),
        .STABLE_TICKS(3),
        .LONG_TICKS(5)
    ) dut (
        .clk(clk),
        .rst_a(rst_a),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (bus.btn_press[i] === 1'b1) n_press[i]++;
            if (bus.btn_release[i] === 1'b1) n_rel[i]++;
            if (bus.btn_long[i] === 1'b1) n_long[i]++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (bus.tick !== 1'b1 && n < 40);
        if (bus.tick !== 1'b1) chk("tick_timeout", 32'(bus.tick), 32'd1);
    endtask

    initial begin
        int n;
        int seen;
        int ps;
        int rs;
        rst_a       = 1'b0;
        bus.btn_in  = 4'b0000;
        bus.enable  = 1'b1;
        repeat (3) step();
        chk("rst_tick", 32'(bus.tick), 32'd0);
        chk("rst_level", 32'(bus.btn_level), 32'd0);
        chk("rst_strobes", 32'({bus.btn_press, bus.btn_release, bus.btn_long}), 32'd0);

        rst_a = 1'b1;
        wait_tick(n);
        chk("first_tick", 32'(n), 32'd10);
        step();
        chk("tick_one_cycle", 32'(bus.tick), 32'd0);
        wait_tick(n);
        chk("tick_period", 32'(n), 32'd9);
        repeat (3) wait_tick(n);
        chk("idle_level", 32'(bus.btn_level), 32'd0);
        chk("idle_strobes", 32'(n_press[0] + n_press[1] + n_press[2] + n_press[3] +
                                n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3]), 32'd0);

        bus.btn_in = 4'b0001;
        repeat (3) wait_tick(n);
        chk("ch0_pre_level", 32'(bus.btn_level), 32'd0);
        step();
        chk("ch0_level", 32'(bus.btn_level), 32'b0001);
        chk("ch0_press", 32'(bus.btn_press), 32'b0001);
        step();
        chk("ch0_press_1clk", 32'(bus.btn_press), 32'd0);

        wait_tick(n);
        bus.btn_in = 4'b0011;
        repeat (2) wait_tick(n);
        bus.btn_in = 4'b0001;
        repeat (3) wait_tick(n);
        chk("glitch_level", 32'(bus.btn_level), 32'b0001);
        chk("glitch_press", 32'(n_press[1]), 32'd0);

        bus.btn_in = 4'b0011;
        repeat (2) wait_tick(n);
        step();
        chk("ch1_cnt_restart", 32'(bus.btn_level), 32'b0001);
        wait_tick(n);
        step();
        chk("ch1_level", 32'(bus.btn_level), 32'b0011);
        chk("ch1_press", 32'(bus.btn_press), 32'b0010);

        wait_tick(n);
        bus.btn_in = 4'b0000;
        repeat (3) wait_tick(n);
        chk("rel_pre_level", 32'(bus.btn_level), 32'b0011);
        step();
        chk("rel_level", 32'(bus.btn_level), 32'd0);
        chk("rel_strobe", 32'(bus.btn_release), 32'b0011);
        chk("rel_no_press", 32'(bus.btn_press), 32'd0);
        step();
        chk("rel_1clk", 32'(bus.btn_release), 32'd0);
        chk("ch0_press_count", 32'(n_press[0]), 32'd1);

        wait_tick(n);
        bus.btn_in = 4'b1100;
        repeat (3) wait_tick(n);
        step();
        chk("dual_press", 32'(bus.btn_press), 32'b1100);
        chk("dual_level", 32'(bus.btn_level), 32'b1100);

        wait_tick(n);
        bus.btn_in = 4'b0101;
        repeat (2) wait_tick(n);
        step();
        bus.enable = 1'b0;
        ps = n_press[0] + n_press[1] + n_press[2] + n_press[3];
        rs = n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3];
        seen = 0;
        repeat (30) begin
            step();
            if (bus.tick === 1'b1) seen++;
        end
        chk("dis_no_tick", 32'(seen), 32'd0);
        chk("dis_level", 32'(bus.btn_level), 32'b1100);
        chk("dis_strobes", 32'(n_press[0] + n_press[1] + n_press[2] + n_press[3] +
                               n_rel[0] + n_rel[1] + n_rel[2] + n_rel[3] - ps - rs), 32'd0);

        bus.enable = 1'b1;
        wait_tick(n);
        chk("reen_first_tick", 32'(n), 32'd10);
        wait_tick(n);
        step();
        chk("reen_fresh", 32'(bus.btn_level), 32'b1100);
        wait_tick(n);
        step();
        chk("reen_level", 32'(bus.btn_level), 32'b0101);
        chk("reen_press", 32'(bus.btn_press), 32'b0001);
        chk("reen_release", 32'(bus.btn_release), 32'b1000);

        repeat (5) wait_tick(n);
        chk("long_pre", 32'(bus.btn_long), 32'd0);
        step();
`ifdef DEBOUNCE_SCHED_LONG_PRESS_EN
        chk("long_pulse", 32'(bus.btn_long), 32'b0001);
`else
        chk("long_pulse", 32'(bus.btn_long), 32'd0);
`endif
        step();
        chk("long_1clk", 32'(bus.btn_long), 32'd0);
        repeat (3) wait_tick(n);
`ifdef DEBOUNCE_SCHED_LONG_PRESS_EN
        chk("long_once_ch0", 32'(n_long[0]), 32'd1);
        chk("long_once_ch2", 32'(n_long[2]), 32'd1);
`else
        chk("long_none", 32'(n_long[0] + n_long[1] + n_long[2] + n_long[3]), 32'd0);
`endif

        #2;
        rst_a = 1'b0;
        #1;
        chk("arst_tick", 32'(bus.tick), 32'd0);
        chk("arst_level", 32'(bus.btn_level), 32'd0);
        chk("arst_strobes", 32'({bus.btn_press, bus.btn_release, bus.btn_long}), 32'd0);
        rs = n_rel[0];
        bus.btn_in = 4'b0000;
        repeat (2) step();
        rst_a = 1'b1;
        repeat (4) wait_tick(n);
        step();
        chk("arst_no_release", 32'(n_rel[0]), 32'(rs));
        chk("arst_level_after", 32'(bus.btn_level), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
